pe_feeder: RTL

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pe_feeder.sv
// pe_feeder: buffers one job of weights and ifmap words from an upstream
// valid/ready stream, then replays them to a PE under its Ready flag.
//
//   state     | meaning
//   S_IDLE    | no job; waits for a start pulse
//   S_FILL    | accepting N_W+N_I words into the local buffer
//   S_WAIT_PE | buffer full; waits for the PE to raise Ready
//   S_SEND_W  | issuing the N_W weight words
//   S_SEND_I  | issuing the N_I ifmap words
//   S_DONE    | job finished; raises done on the way back to IDLE
module pe_feeder #(
  parameter int DATA_W = 32,
  parameter int N_W    = 3,
  parameter int N_I    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              pe_ready,
  output logic              pe_ena,
  output logic [DATA_W-1:0] pe_value,
  output logic              pe_weight_wea,
  output logic              pe_ifmap_wea,
  output logic              busy,
  output logic              done
);

  localparam int N_TOT = N_W + N_I;
  localparam int CNT_W = $clog2(N_TOT);

  localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(N_TOT - 1);
  localparam logic [CNT_W-1:0] LAST_W  = CNT_W'(N_W - 1);
  localparam logic [CNT_W-1:0] LAST_I  = CNT_W'(N_I - 1);
  localparam logic [CNT_W-1:0] OFS_I   = CNT_W'(N_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT_PE,
    S_SEND_W,
    S_SEND_I,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                pe_ena_q, pe_ena_d;
  logic [DATA_W-1:0]   pe_value_q, pe_value_d;
  logic                w_wea_q, w_wea_d;
  logic                i_wea_q, i_wea_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   word_mem_q [N_TOT];
  logic                mem_we;
  logic [CNT_W-1:0]    rd_idx;

  // Handshake and busy are pure state decodes so they react within the cycle.
  assign s_ready = (state_q == S_FILL);
  assign busy    = (state_q != S_IDLE);

  assign pe_ena        = pe_ena_q;
  assign pe_value      = pe_value_q;
  assign pe_weight_wea = w_wea_q;
  assign pe_ifmap_wea  = i_wea_q;
  assign done          = done_q;

  // Ifmap words sit directly after the weights in the buffer.
  assign rd_idx = (state_q == S_SEND_I) ? (rd_cnt_q + OFS_I) : rd_cnt_q;
  assign mem_we = s_ready && s_valid;

  // Job buffer; contents are don't-care between jobs, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      word_mem_q[wr_cnt_q] <= s_data;
    end
  end

  // State, counters and all PE-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      pe_ena_q   <= 1'b0;
      pe_value_q <= '0;
      w_wea_q    <= 1'b0;
      i_wea_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      pe_ena_q   <= pe_ena_d;
      pe_value_q <= pe_value_d;
      w_wea_q    <= w_wea_d;
      i_wea_q    <= i_wea_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output decode; abort overrides every transition.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    pe_ena_d   = pe_ena_q;
    pe_value_d = '0;
    w_wea_d    = 1'b0;
    i_wea_d    = 1'b0;
    done_d     = 1'b0;

    if (abort) begin
      state_d  = S_IDLE;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      pe_ena_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_FILL;
            pe_ena_d = 1'b1;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
          end
        end
        S_FILL: begin
          if (s_valid) begin
            if (wr_cnt_q == LAST_WR) begin
              wr_cnt_d = '0;
              state_d  = S_WAIT_PE;
            end else begin
              wr_cnt_d = wr_cnt_q + 1'b1;
            end
          end
        end
        S_WAIT_PE: begin
          if (pe_ready) begin
            state_d = S_SEND_W;
          end
        end
        S_SEND_W: begin
          if (pe_ready) begin
            w_wea_d    = 1'b1;
            pe_value_d = word_mem_q[rd_idx];
            if (rd_cnt_q == LAST_W) begin
              rd_cnt_d = '0;
              state_d  = S_SEND_I;
            end else begin
              rd_cnt_d = rd_cnt_q + 1'b1;
            end
          end
        end
        S_SEND_I: begin
          if (pe_ready) begin
            i_wea_d    = 1'b1;
            pe_value_d = word_mem_q[rd_idx];
            if (rd_cnt_q == LAST_I) begin
              rd_cnt_d = '0;
              state_d  = S_DONE;
            end else begin
              rd_cnt_d = rd_cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          // pe_ena is left high so the PE can run on the loaded data.
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule
